// File: rtl/riscv_pkg.sv
// Shared opcodes, ALU operation encoding and decode helper for the RV32I subset core.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_op_t;

  // Bit 30 selects SUB only for register ops; for ADDI it is an immediate bit.
  function automatic alu_op_t alu_decode(input logic [2:0] f3, input logic alt, input logic is_r);
    alu_op_t op;
    case (f3)
      3'b000:  op = (is_r && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/riscv_core_alu.sv
// Integer ALU; shifts use only the low five bits of operand b.
import riscv_pkg::*;

module riscv_alu (
  input  alu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  // Pure combinational result select.
  always_comb begin
    y = a + b;
    case (op)
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_SLL:  y = a << b[4:0];
      ALU_SRL:  y = a >> b[4:0];
      ALU_SRA:  y = $unsigned($signed(a) >>> b[4:0]);
      ALU_SLT:  y = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: y = {31'd0, a < b};
      default:  y = a + b;
    endcase
  end
endmodule

// File: rtl/riscv_core_dmem.sv
// 64-word data RAM, word index only, so higher address bits simply wrap.
module riscv_dmem (
  input  logic        clk,
  input  logic        we,
  input  logic [5:0]  widx,
  input  logic [31:0] wd,
  output logic [31:0] rd
);
  logic [31:0] mem [0:63];

  // Store on the clock edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wd;
  end

  assign rd = mem[widx];
endmodule

// File: rtl/riscv_core_imem.sv
// Instruction ROM; contents are preloaded from outside before reset is released.
import riscv_pkg::*;

module riscv_imem #(
  parameter int IMEM_DEPTH = 28
) (
  input  logic [29:0] word_idx,
  output logic [31:0] inst
);
  localparam int AW = $clog2(IMEM_DEPTH);

  logic [31:0] tab_inst [0:IMEM_DEPTH-1];

  // Combinational fetch; anything beyond the populated range reads as a NOP.
  always_comb begin
    inst = NOP;
    if ({2'b00, word_idx} < 32'(IMEM_DEPTH)) inst = tab_inst[word_idx[AW-1:0]];
  end
endmodule

// File: rtl/riscv_core_regfile.sv
// 32 x 32 register file, two async read ports, one sync write port; x0 hardwired to zero.
module riscv_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] regs [0:31];

  // Synchronous clear on reset, otherwise write-back of the retiring instruction.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (rd != 5'd0)) begin
      regs[rd] <= wd;
    end
  end

  assign rd1 = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rd2 = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
endmodule

// File: rtl/riscv_core.sv
// Single-cycle RV32I-subset core: fetch, decode, execute and write back every clock.
import riscv_pkg::*;

module riscv_core #(
  parameter int IMEM_DEPTH = 28
) (
  input  logic clk,
  input  logic reset
);
  logic [31:0] pc_q, pc_d, pc_plus4;
  logic [31:0] inst, rd1, rd2, alu_b, alu_y, dm_rd, wb;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic        rf_we, dm_we, taken;
  alu_op_t     alu_op;

  riscv_imem #(.IMEM_DEPTH(IMEM_DEPTH)) imem (.word_idx(pc_q[31:2]), .inst(inst));

  riscv_regfile rf (
    .clk(clk), .reset(reset), .rs1(inst[19:15]), .rs2(inst[24:20]), .rd(inst[11:7]),
    .we(rf_we & reset), .wd(wb), .rd1(rd1), .rd2(rd2)
  );

  riscv_alu u_alu (.op(alu_op), .a(rd1), .b(alu_b), .y(alu_y));

  riscv_dmem dmem (.clk(clk), .we(dm_we & reset), .widx(alu_y[7:2]), .wd(rd2), .rd(dm_rd));

  assign opcode   = inst[6:0];
  assign f3       = inst[14:12];
  assign pc_plus4 = pc_q + 32'd4;
  assign imm_i    = {{20{inst[31]}}, inst[31:20]};
  assign imm_s    = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b    = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u    = {inst[31:12], 12'd0};
  assign imm_j    = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // Branch condition; BLTU/BGEU are outside the subset and never taken.
  always_comb begin
    case (f3)
      3'b000:  taken = (rd1 == rd2);
      3'b001:  taken = (rd1 != rd2);
      3'b100:  taken = ($signed(rd1) < $signed(rd2));
      3'b101:  taken = ($signed(rd1) >= $signed(rd2));
      default: taken = 1'b0;
    endcase
  end

  // Decode: unrecognised opcodes fall through to the NOP defaults.
  always_comb begin
    alu_op = ALU_ADD;
    alu_b  = rd2;
    rf_we  = 1'b0;
    dm_we  = 1'b0;
    wb     = alu_y;
    pc_d   = pc_plus4;
    case (opcode)
      OP_R:      begin alu_op = alu_decode(f3, inst[30], 1'b1); rf_we = 1'b1; end
      OP_I:      begin alu_op = alu_decode(f3, inst[30], 1'b0); alu_b = imm_i; rf_we = 1'b1; end
      OP_LOAD:   begin alu_b = imm_i; wb = dm_rd; rf_we = 1'b1; end
      OP_STORE:  begin alu_b = imm_s; dm_we = 1'b1; end
      OP_BRANCH: begin if (taken) pc_d = pc_q + imm_b; end
      OP_JAL:    begin wb = pc_plus4; rf_we = 1'b1; pc_d = pc_q + imm_j; end
      OP_JALR:   begin alu_b = imm_i; wb = pc_plus4; rf_we = 1'b1; pc_d = alu_y & ~32'd1; end
      OP_LUI:    begin wb = imm_u; rf_we = 1'b1; end
      OP_AUIPC:  begin wb = pc_q + imm_u; rf_we = 1'b1; end
      default:   ;
    endcase
  end

  // Program counter with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) pc_q <= '0;
    else        pc_q <= pc_d;
  end
endmodule

// File: tb/tb_riscv_core.sv
// Directed-program bench for riscv_core: preloads imem and inspects pc/rf/dmem hierarchically.
module tb_riscv_core;
  localparam int DEPTH = 28;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  riscv_core dut (.clk(clk), .reset(reset));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input int n, input logic [31:0] exp);
    chk(tag, dut.rf.regs[n], exp);
  endtask

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
    return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic put(input int idx, input logic [31:0] w);
    dut.imem.tab_inst[idx] = w;
  endtask

  task automatic begin_prog();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) put(i, 32'h00000013);
  endtask

  task automatic regs_or(input int lo, input int hi, output logic [31:0] acc);
    acc = '0;
    for (int i = lo; i <= hi; i++) acc = acc | dut.rf.regs[i];
  endtask

  task automatic finish_reset(input string tag);
    logic [31:0] acc;
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_rst_pc"}, dut.pc_q, 32'd0);
    regs_or(0, 31, acc);
    chk({tag, "_rst_regs"}, acc, 32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] acc;

    // Program 1: ALU, x0, shifts, memory, LUI/AUIPC, address wrap
    begin_prog();
    put(0,  addi(1, 0, 5));
    put(1,  addi(2, 0, -3));
    put(2,  enc_r(7'b0000000, 2, 1, 3'b000, 3));
    put(3,  enc_r(7'b0100000, 2, 1, 3'b000, 4));
    put(4,  enc_r(7'b0000000, 1, 2, 3'b010, 5));
    put(5,  addi(0, 0, 7));
    put(6,  addi(6, 0, -16));
    put(7,  enc_i(32'h402, 6, 3'b101, 7, 7'b0010011));
    put(8,  enc_i(32'd28,  6, 3'b101, 8, 7'b0010011));
    put(9,  addi(10, 0, 32'h55));
    put(10, enc_s(8, 10, 0));
    put(11, enc_i(8, 0, 3'b010, 9, 7'b0000011));
    put(12, {20'h12345, 5'd11, 7'b0110111});
    put(13, {20'h00001, 5'd12, 7'b0010111});
    put(14, enc_r(7'b0000000, 2, 6, 3'b101, 14));
    put(15, enc_r(7'b0000000, 2, 1, 3'b111, 13));
    put(16, enc_r(7'b0000000, 2, 1, 3'b011, 15));
    put(17, enc_r(7'b0000000, 1, 1, 3'b001, 16));
    put(18, enc_i(32'd264, 0, 3'b010, 18, 7'b0000011));
    finish_reset("p1");
    step(1);
    chk("p1_first_pc", dut.pc_q, 32'd4);
    chk_reg("p1_first_x1", 1, 32'd5);
    step(18);
    chk("p1_pc", dut.pc_q, 32'd76);
    chk_reg("addi_x1", 1, 32'd5);
    chk_reg("addi_neg_x2", 2, 32'hFFFF_FFFD);
    chk_reg("add_x3", 3, 32'd2);
    chk_reg("sub_x4", 4, 32'd8);
    chk_reg("slt_x5", 5, 32'd1);
    chk_reg("x0_zero", 0, 32'd0);
    chk_reg("addi_x6", 6, 32'hFFFF_FFF0);
    chk_reg("srai_x7", 7, 32'hFFFF_FFFC);
    chk_reg("srli_x8", 8, 32'h0000_000F);
    chk("sw_mem2", dut.dmem.mem[2], 32'h55);
    chk_reg("lw_x9", 9, 32'h55);
    chk_reg("lui_x11", 11, 32'h1234_5000);
    chk_reg("auipc_x12", 12, 32'h0000_1034);
    chk_reg("srl_mask_x14", 14, 32'd7);
    chk_reg("and_x13", 13, 32'd5);
    chk_reg("sltu_x15", 15, 32'd1);
    chk_reg("sll_x16", 16, 32'h0000_00A0);
    chk_reg("lw_wrap_x18", 18, 32'h55);

    // Program 2: branches and jumps
    begin_prog();
    put(0,  addi(2, 0, 1));
    put(1,  enc_b(8, 2, 2, 3'b000));
    put(2,  addi(3, 0, 9));
    put(3,  enc_j(8, 1));
    put(4,  addi(3, 0, 7));
    put(5,  enc_b(8, 2, 2, 3'b001));
    put(6,  enc_i(32'd21, 1, 3'b000, 5, 7'b1100111));
    put(7,  addi(6, 0, 1));
    put(8,  addi(6, 0, 1));
    put(9,  enc_b(8, 2, 0, 3'b101));
    put(10, enc_b(8, 2, 0, 3'b100));
    put(11, addi(7, 0, 3));
    finish_reset("p2");
    step(5);
    chk("jalr_pc", dut.pc_q, 32'd36);
    chk_reg("jal_link_x1", 1, 32'd16);
    chk_reg("beq_skip_x3", 3, 32'd0);
    chk_reg("jalr_link_x5", 5, 32'd28);
    chk_reg("jalr_skip_x6", 6, 32'd0);
    step(2);
    chk("blt_pc", dut.pc_q, 32'd48);
    chk_reg("blt_skip_x7", 7, 32'd0);

    // Program 3: BNE loop, reset mid-loop, running off the end of imem
    begin_prog();
    put(0, addi(1, 0, 0));
    put(1, addi(2, 0, 4));
    put(2, addi(1, 1, 1));
    put(3, enc_b(-4, 2, 1, 3'b001));
    finish_reset("p3");
    step(4);
    chk("loop_mid_pc", dut.pc_q, 32'd8);
    chk_reg("loop_mid_x1", 1, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    step(1);
    chk("midrst_pc", dut.pc_q, 32'd0);
    chk_reg("midrst_x1", 1, 32'd0);
    chk_reg("midrst_x2", 2, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step(10);
    chk("loop_end_pc", dut.pc_q, 32'd16);
    chk_reg("loop_end_x1", 1, 32'd4);
    step(30);
    chk("past_end_pc", dut.pc_q, 32'd136);
    chk_reg("past_end_x1", 1, 32'd4);
    chk_reg("past_end_x2", 2, 32'd4);
    regs_or(3, 31, acc);
    chk("past_end_others", acc, 32'd0);
    chk("dmem_kept", dut.dmem.mem[2], 32'h55);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
